pong_graph_anim: RTL and testbench

- Animated successor to the fixed-object pong graphics generator: renders wall, paddle and ball, moves the paddle from two buttons, and moves the ball with bounce, hit and miss handling once per frame.
- Sits between the VGA sync generator (pixel_x, pixel_y, video_on, pixel_tick) and the rgb output port of the pong top level.
- Geometry, speeds and colour width are parameters. Defaults reproduce the fixed layout.

---
 rtl/pong_graph_anim.sv | 134 +++++++++++++
 tb/tb_pong_graph_anim.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_graph_anim.sv
// Pong graphics with motion: renders wall, paddle and ball, and once per frame
// moves the paddle from the buttons and the ball with bounce, hit and miss rules.
module pong_graph_anim #(
  parameter int H_DISP    = 640,
  parameter int V_DISP    = 480,
  parameter int WALL_XL   = 32,
  parameter int WALL_XR   = 35,
  parameter int PAD_XL    = 600,
  parameter int PAD_XR    = 603,
  parameter int PAD_H     = 72,
  parameter int PAD_TOP0  = 204,
  parameter int PAD_V     = 4,
  parameter int BALL_SIZE = 8,
  parameter int BALL_X0   = 580,
  parameter int BALL_Y0   = 238,
  parameter int BALL_V    = 2,
  parameter int RGB_W     = 12,
  parameter logic [RGB_W-1:0] WALL_RGB = 12'h060,
  parameter logic [RGB_W-1:0] PAD_RGB  = 12'hFF0,
  parameter logic [RGB_W-1:0] BALL_RGB = 12'hF0F,
  parameter logic [RGB_W-1:0] BG_RGB   = 12'h000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixel_tick,
  input  logic             video_on,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             btn_up,
  input  logic             btn_dn,
  output logic [RGB_W-1:0] rgb,
  output logic             refr_tick,
  output logic [7:0]       hit_cnt,
  output logic [7:0]       miss_cnt
);

  localparam int VW = $clog2(BALL_V) + 2;
  localparam logic signed [VW-1:0] V_POS = VW'(BALL_V);
  localparam logic signed [VW-1:0] V_NEG = VW'(-BALL_V);

  logic [9:0]           pad_top, ball_x, ball_y;
  logic [9:0]           pad_top_n, ball_x_n, ball_y_n;
  logic signed [VW-1:0] vx, vy, vx_n, vy_n;
  logic [10:0]          ball_xr, ball_yb, pad_bot;
  logic                 hit, miss, refr_n;
  logic                 wall_on, pad_on, ball_on;
  logic [RGB_W-1:0]     rgb_n;

  // Object right/bottom edges carry an extra bit so the edge tests never wrap.
  assign ball_xr = {1'b0, ball_x} + 11'(BALL_SIZE);
  assign ball_yb = {1'b0, ball_y} + 11'(BALL_SIZE);
  assign pad_bot = {1'b0, pad_top} + 11'(PAD_H);

  // pixel_tick is the valid strobe for pixel_x/pixel_y/video_on; there is no
  // back-pressure, so every ticked pixel yields an rgb value one clk later.
  assign refr_n = pixel_tick && (pixel_x == '0) && (pixel_y == 10'(V_DISP));

  always_comb begin : frame_update
    pad_top_n = pad_top;
    ball_x_n  = ball_x;
    ball_y_n  = ball_y;
    vx_n      = vx;
    vy_n      = vy;
    hit       = 1'b0;
    miss      = 1'b0;
    if (btn_up && !btn_dn && pad_top >= 10'(PAD_V))
      pad_top_n = pad_top - 10'(PAD_V);
    else if (btn_dn && !btn_up && (pad_bot + 11'(PAD_V)) <= 11'(V_DISP - 1))
      pad_top_n = pad_top + 10'(PAD_V);
    if (ball_y <= 10'(BALL_V))
      vy_n = V_POS;
    if (ball_yb >= 11'(V_DISP - 1 - BALL_V))
      vy_n = V_NEG;
    if (ball_x <= 10'(WALL_XR + BALL_V))
      vx_n = V_POS;
    hit  = (ball_xr >= 11'(PAD_XL)) && (ball_xr <= 11'(PAD_XR)) &&
           ({1'b0, ball_y} <= pad_bot) && (ball_yb >= {1'b0, pad_top});
    miss = !hit && (ball_xr > 11'(H_DISP - 1));
    if (hit)
      vx_n = V_NEG;
    if (miss) begin
      ball_x_n = 10'(BALL_X0);
      ball_y_n = 10'(BALL_Y0);
      vx_n     = V_NEG;
      vy_n     = V_POS;
    end else begin
      // Movement uses the velocity held before this frame's bounce decisions.
      ball_x_n = ball_x + {{(10-VW){vx[VW-1]}}, vx};
      ball_y_n = ball_y + {{(10-VW){vy[VW-1]}}, vy};
    end
  end

  assign wall_on = (pixel_x >= 10'(WALL_XL)) && (pixel_x <= 10'(WALL_XR));
  assign pad_on  = (pixel_x >= 10'(PAD_XL)) && (pixel_x <= 10'(PAD_XR)) &&
                   (pixel_y >= pad_top) && ({1'b0, pixel_y} <= pad_bot);
  assign ball_on = (pixel_x >= ball_x) && ({1'b0, pixel_x} <= ball_xr) &&
                   (pixel_y >= ball_y) && ({1'b0, pixel_y} <= ball_yb);

  always_comb begin : render
    rgb_n = BG_RGB;
    if (!video_on)    rgb_n = '0;
    else if (ball_on) rgb_n = BALL_RGB;
    else if (pad_on)  rgb_n = PAD_RGB;
    else if (wall_on) rgb_n = WALL_RGB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      refr_tick <= 1'b0;
      hit_cnt   <= 8'd0;
      miss_cnt  <= 8'd0;
      pad_top   <= 10'(PAD_TOP0);
      ball_x    <= 10'(BALL_X0);
      ball_y    <= 10'(BALL_Y0);
      vx        <= V_NEG;
      vy        <= V_POS;
    end else begin
      refr_tick <= refr_n;
      if (pixel_tick)
        rgb <= rgb_n;
      if (refr_tick) begin
        pad_top <= pad_top_n;
        ball_x  <= ball_x_n;
        ball_y  <= ball_y_n;
        vx      <= vx_n;
        vy      <= vy_n;
        if (hit)  hit_cnt  <= hit_cnt + 8'd1;
        if (miss) miss_cnt <= miss_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pong_graph_anim.sv
// Randomized bench for pong_graph_anim: pixels are probed in arbitrary order and
// compared with a frame-level game model; counters are checked after each update.
module tb_pong_graph_anim;

  localparam int NF = 1800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixel_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        btn_up = 1'b0;
  logic        btn_dn = 1'b0;
  logic [11:0] rgb;
  logic        refr_tick;
  logic [7:0]  hit_cnt;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [15:0] cnt_q[$];

  int m_pad, m_bx, m_by, m_vx, m_vy, m_hits, m_misses;

  pong_graph_anim dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn_up), .btn_dn(btn_dn),
    .rgb(rgb), .refr_tick(refr_tick), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pad = 204; m_bx = 580; m_by = 238; m_vx = -2; m_vy = 2;
    m_hits = 0; m_misses = 0;
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit von);
    if (!von) return 12'h000;
    if (x >= m_bx && x <= m_bx + 8 && y >= m_by && y <= m_by + 8) return 12'hF0F;
    if (x >= 600 && x <= 603 && y >= m_pad && y <= m_pad + 72) return 12'hFF0;
    if (x >= 32 && x <= 35) return 12'h060;
    return 12'h000;
  endfunction

  // One frame of game rules, applied to the state seen during that frame.
  function automatic void model_frame(input bit up, input bit dn);
    int nvx, nvy;
    bit hit, miss;
    nvx = m_vx; nvy = m_vy;
    if (m_by <= 2) nvy = 2;
    if (m_by + 8 >= 477) nvy = -2;
    if (m_bx <= 37) nvx = 2;
    hit  = (m_bx + 8 >= 600) && (m_bx + 8 <= 603) && (m_by <= m_pad + 72) && (m_by + 8 >= m_pad);
    miss = !hit && (m_bx + 8 > 639);
    if (hit) begin
      nvx = -2;
      m_hits = (m_hits + 1) % 256;
    end
    if (miss) begin
      m_bx = 580; m_by = 238; m_vx = -2; m_vy = 2;
      m_misses = (m_misses + 1) % 256;
    end else begin
      m_bx = (m_bx + m_vx) & 1023;
      m_by = (m_by + m_vy) & 1023;
      m_vx = nvx; m_vy = nvy;
    end
    if (up && !dn && m_pad >= 4) m_pad -= 4;
    else if (dn && !up && m_pad + 76 <= 479) m_pad += 4;
  endfunction

  task automatic tick_pixel(input int x, input int y, input bit von);
    int gap;
    @(negedge clk);
    pixel_x = x[9:0]; pixel_y = y[9:0]; video_on = von; pixel_tick = 1'b1;
    exp_q.push_back(model_rgb(x, y, von));
    gap = $urandom_range(0, 3);
    if (gap > 0) begin
      @(negedge clk);
      pixel_tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic probe_at(input int xi, input int yi, input bit rand_off);
    int x, y;
    bit von;
    x = xi & 1023; y = yi & 1023;
    if (x == 0 && y == 480) y = 481;
    von = (x < 640) && (y < 480) && (!rand_off || $urandom_range(0, 9) != 0);
    tick_pixel(x, y, von);
  endtask

  task automatic probe_rand();
    case ($urandom_range(0, 3))
      0: probe_at($urandom_range(0, 799), $urandom_range(0, 524), 1'b1);
      1: probe_at(m_bx - 3 + $urandom_range(0, 14), m_by - 3 + $urandom_range(0, 14), 1'b1);
      2: probe_at(596 + $urandom_range(0, 11), m_pad - 3 + $urandom_range(0, 78), 1'b1);
      default: probe_at(28 + $urandom_range(0, 11), $urandom_range(0, 479), 1'b1);
    endcase
  endtask

  task automatic check_reset_outputs();
    chk("rst_rgb", rgb, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    pixel_tick = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs();
  endtask

  task automatic trigger(input bit rst_after);
    @(negedge clk);
    pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0; pixel_tick = 1'b1;
    exp_q.push_back(model_rgb(0, 480, 1'b0));
    model_frame(btn_up, btn_dn);
    cnt_q.push_back({8'(m_hits), 8'(m_misses)});
    @(negedge clk);
    pixel_tick = 1'b0; rst = rst_after;
  endtask

  // Monitor: refr_tick every cycle, rgb whenever a pixel was ticked.
  always begin : mon_rgb
    bit t, r, trig;
    @(posedge clk);
    t = pixel_tick; r = rst;
    trig = t && !r && pixel_x == 10'd0 && pixel_y == 10'd480;
    #1;
    chk("refr_tick", refr_tick, trig);
    if (t && !r) begin
      if (exp_q.size() == 0) chk("rgb_underflow", 1, 0);
      else chk("rgb", rgb, exp_q.pop_front());
    end
  end

  // Monitor: counters settle on the clk after refr_tick, unless reset lands there.
  always begin : mon_cnt
    logic [15:0] e;
    bit r;
    @(posedge clk);
    #1;
    if (refr_tick === 1'b1) begin
      e = 16'h0;
      if (cnt_q.size() == 0) chk("cnt_underflow", 1, 0);
      else e = cnt_q.pop_front();
      @(posedge clk);
      r = rst;
      #1;
      if (r) e = 16'h0;
      chk("hit_cnt", hit_cnt, e[15:8]);
      chk("miss_cnt", miss_cnt, e[7:0]);
    end
  end

  initial begin : driver
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    chk("rst_refr_tick", refr_tick, 0);
    rst = 1'b0;
    for (int f = 0; f < NF; f++) begin
      bit up, dn;
      int pc, bc;
      pc = m_pad + 36; bc = m_by + 4;
      if (f < 60) begin up = 1'b1; dn = 1'b0; end
      else if (f < 65) begin up = 1'b1; dn = 1'b1; end
      else if (f >= 600 && f < 1400) begin up = (pc > bc + 4); dn = (pc < bc - 4); end
      else begin up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      btn_up = up; btn_dn = dn;
      probe_at(m_bx, m_by, 1'b0);
      probe_at(m_bx + 8, m_by + 8, 1'b0);
      probe_at(m_bx - 1, m_by, 1'b0);
      probe_at(m_bx + 8, m_by + 9, 1'b0);
      probe_at(600, m_pad + 72, 1'b0);
      probe_at(599, m_pad, 1'b0);
      for (int i = 0; i < 8; i++) begin
        probe_rand();
        if (f == 600 && i == 3) reset_pulse();
      end
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0; pixel_tick = 1'b0;
      end
      trigger(f == 1750);
      if (f == 1750) begin
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs();
      end
    end
    repeat (8) @(negedge clk);
    chk("rgb_queue_drained", exp_q.size(), 0);
    chk("cnt_queue_drained", cnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
